instr_mem_responder: RTL and testbench

// - Instruction-memory responder for the fetch stage: accepts word-fetch requests (addr) and returns

---
 rtl/instr_mem_pkg.sv | 18 +
 rtl/instr_mem_responder_if.sv | 27 ++
 rtl/instr_mem_responder_resp_fifo.sv | 62 ++++++
 rtl/instr_mem_responder.sv | 148 ++++++++++++++
 tb/tb_instr_mem_responder.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package instr_mem_pkg;

    // Instruction returned for any faulting fetch (addi x0, x0, 0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Byte-address bits below the word index.
    localparam int ADDR_LSB = 2;

    // One response slot: the instruction word and its fault flag.
    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

endpackage

// File: rtl/instr_mem_responder_if.sv
// Fetch request/response channel bundle between the fetch stage and the responder.
// Latency: none (wires only).
// Backpressure: valid/ready on both the request and the response direction.
interface instr_mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] req_addr;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_err;

    // Fetch stage side.
    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    // Responder side.
    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/instr_mem_responder_resp_fifo.sv
// Synchronous FIFO of resp_t entries with occupancy count.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored when full, pop ignored when empty; the caller keeps both from happening.
module resp_fifo
    import instr_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  resp_t                      push_dat,
    input  logic                       pop,
    output resp_t                      head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    resp_t          mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: in-order word fetches from an on-chip store with a load port.
// Latency: response visible LATENCY cycles after the request handshake when the buffer is empty.
// Backpressure: req_ready drops once FIFO_DEPTH requests are outstanding; responses wait for resp_ready.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_mem_responder_if.slave  bus,
    input  logic                  ld_en,
    input  logic [DATA_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] store [DEPTH];

    logic                  ready;
    logic                  accept;
    logic                  pop;
    logic [CNT_W-1:0]      outstanding;

    logic [DATA_WIDTH-1:0] req_word;
    logic [IDX_W-1:0]      req_idx;
    logic                  req_bad;
    resp_t                 lookup;

    logic [DATA_WIDTH-1:0] ld_word;
    logic [IDX_W-1:0]      ld_idx;
    logic                  ld_ok;

    logic                  fifo_push;
    resp_t                 fifo_push_dat;
    resp_t                 head;
    resp_t                 last;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    // Outstanding covers both the read pipeline and the buffer, so the buffer can never overflow.
    assign ready  = !rst && (outstanding < CNT_W'(FIFO_DEPTH));
    assign accept = bus.req_valid && ready;
    assign pop    = !fifo_empty && bus.resp_ready;

    assign req_word = bus.req_addr >> ADDR_LSB;
    assign req_idx  = req_word[IDX_W-1:0];
    assign req_bad  = (bus.req_addr[ADDR_LSB-1:0] != '0) || (req_word >= DATA_WIDTH'(DEPTH));

    assign ld_word = ld_addr >> ADDR_LSB;
    assign ld_idx  = ld_word[IDX_W-1:0];
    assign ld_ok   = ld_word < DATA_WIDTH'(DEPTH);

    // Store lookup; faulting addresses never touch the array and return a NOP.
    always_comb begin
        lookup.data = NOP_INSTR;
        lookup.err  = 1'b1;
        if (!req_bad) begin
            lookup.data = store[req_idx];
            lookup.err  = 1'b0;
        end
    end

    // Load port write; a same-cycle request already sampled the old word through lookup.
    always_ff @(posedge clk) begin
        if (ld_en && ld_ok) store[ld_idx] <= ld_data;
    end

    // Request count in flight: +1 per handshake, -1 per retired response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign fifo_push     = accept;
            assign fifo_push_dat = lookup;
        end else begin : g_pipe
            logic  pipe_vld [LATENCY-1];
            resp_t pipe_dat [LATENCY-1];

            // Valid shift chain; reset discards everything in flight.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY - 1; i++) pipe_vld[i] <= 1'b0;
                end else begin
                    pipe_vld[0] <= accept;
                    for (int i = 1; i < LATENCY - 1; i++) pipe_vld[i] <= pipe_vld[i-1];
                end
            end

            // Payload shift chain, qualified by the valid chain.
            always_ff @(posedge clk) begin
                pipe_dat[0] <= lookup;
                for (int i = 1; i < LATENCY - 1; i++) pipe_dat[i] <= pipe_dat[i-1];
            end

            assign fifo_push     = pipe_vld[LATENCY-2];
            assign fifo_push_dat = pipe_dat[LATENCY-2];
        end
    endgenerate

    resp_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_resp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (fifo_push_dat),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Last retired response, shown on the data pins while the buffer is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= '0;
        end else if (pop) begin
            last <= head;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.resp_valid = !fifo_empty;
    assign bus.resp_data  = fifo_empty ? last.data : head.data;
    assign bus.resp_err   = fifo_empty ? last.err  : head.err;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));
    a_count_bound: assert property (@(posedge clk) disable iff (rst) fifo_count <= outstanding);

endmodule

// File: tb/tb_instr_mem_responder.sv
module tb_instr_mem_responder;
    import instr_mem_pkg::*;

    localparam int LAT = 2;
    localparam int FD  = 4;
    localparam int DEP = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;

    instr_mem_responder_if #(.DATA_WIDTH(32)) bus();

    instr_mem_responder #(
        .DATA_WIDTH(32), .DEPTH(DEP), .LATENCY(LAT), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    // Reference model: shadow store plus a queue of pending responses with the cycle they become due.
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl_mem [DEP];
    int          outstanding;
    int          cyc;
    logic [31:0] last_data;
    logic        last_err;

    logic        exp_ready, exp_valid, exp_err;
    logic [31:0] exp_data;
    logic        obs_ready, obs_valid, obs_err;
    logic [31:0] obs_data;

    int checks = 0;
    int errors = 0;

    task automatic mdl_reset();
        q.delete();
        outstanding = 0;
        last_data   = '0;
        last_err    = 1'b0;
    endtask

    // One clock cycle: drive after the edge, sample at the falling edge, then advance the model.
    task automatic step(input logic rv, input logic [31:0] ra, input logic rr,
                        input logic le, input logic [31:0] la, input logic [31:0] lv);
        exp_t e;
        @(posedge clk); #1;
        bus.req_valid  = rv;
        bus.req_addr   = ra;
        bus.resp_ready = rr;
        ld_en   = le;
        ld_addr = la;
        ld_data = lv;
        @(negedge clk);
        obs_ready = bus.req_ready;
        obs_valid = bus.resp_valid;
        obs_data  = bus.resp_data;
        obs_err   = bus.resp_err;
        exp_ready = !rst && (outstanding < FD);
        exp_valid = (q.size() > 0) && (q[0].due <= cyc);
        exp_data  = exp_valid ? q[0].data : last_data;
        exp_err   = exp_valid ? q[0].err  : last_err;
        if (rv && exp_ready) begin
            e.err  = (ra[1:0] != 2'b00) || ((ra >> 2) >= DEP);
            e.data = e.err ? NOP_INSTR : mdl_mem[ra[11:2]];
            e.due  = cyc + LAT;
            q.push_back(e);
            outstanding++;
        end
        if (exp_valid && rr) begin
            last_data = q[0].data;
            last_err  = q[0].err;
            void'(q.pop_front());
            outstanding--;
        end
        if (le && ((la >> 2) < DEP)) mdl_mem[la[11:2]] = lv;
        cyc++;
    endtask

    task automatic idle(input logic rr);
        step(1'b0, '0, rr, 1'b0, '0, '0);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, '0, 1'b1, 1'b1, a, d);
    endtask

    task automatic test_reset();
        mdl_reset();
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            checks++; if (obs_ready !== 1'b0)  begin errors++; $display("FAIL reset_ready got %b want 0", obs_ready); end
            checks++; if (obs_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b want 0", obs_valid); end
            checks++; if (obs_data !== 32'h0)  begin errors++; $display("FAIL reset_data got %h want 0", obs_data); end
            checks++; if (obs_err !== 1'b0)    begin errors++; $display("FAIL reset_err got %b want 0", obs_err); end
        end
        rst = 1'b0;
        idle(1'b1);
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", obs_ready); end
    endtask

    task automatic test_basic();
        load(32'h0, 32'h0050_0093);
        load(32'h4, 32'h00a0_0113);
        step(1'b1, 32'h0, 1'b1, 1'b0, '0, '0);
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", obs_ready); end
        step(1'b1, 32'h4, 1'b1, 1'b0, '0, '0);
        checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL basic_early got %b want 0", obs_valid); end
        idle(1'b1);
        checks++; if (obs_valid !== 1'b1 || obs_data !== 32'h0050_0093 || obs_err !== 1'b0) begin
            errors++; $display("FAIL basic_first got v=%b d=%h e=%b want v=1 d=00500093 e=0", obs_valid, obs_data, obs_err);
        end
        idle(1'b1);
        checks++; if (obs_valid !== 1'b1 || obs_data !== 32'h00a0_0113 || obs_err !== 1'b0) begin
            errors++; $display("FAIL basic_second got v=%b d=%h e=%b want v=1 d=00a00113 e=0", obs_valid, obs_data, obs_err);
        end
        idle(1'b1);
        checks++; if (obs_valid !== 1'b0 || obs_data !== 32'h00a0_0113) begin
            errors++; $display("FAIL basic_empty_hold got v=%b d=%h want v=0 d=00a00113", obs_valid, obs_data);
        end
    endtask

    task automatic test_errors();
        step(1'b1, 32'h2, 1'b1, 1'b0, '0, '0);
        step(1'b1, 32'(4 * DEP), 1'b1, 1'b0, '0, '0);
        idle(1'b1);
        checks++; if (obs_valid !== 1'b1 || obs_data !== 32'h13 || obs_err !== 1'b1) begin
            errors++; $display("FAIL err_misaligned got v=%b d=%h e=%b want v=1 d=00000013 e=1", obs_valid, obs_data, obs_err);
        end
        idle(1'b1);
        checks++; if (obs_valid !== 1'b1 || obs_data !== 32'h13 || obs_err !== 1'b1) begin
            errors++; $display("FAIL err_range got v=%b d=%h e=%b want v=1 d=00000013 e=1", obs_valid, obs_data, obs_err);
        end
        idle(1'b1);
        checks++; if (obs_valid !== 1'b0 || obs_err !== 1'b1) begin
            errors++; $display("FAIL err_hold got v=%b e=%b want v=0 e=1", obs_valid, obs_err);
        end
    endtask

    task automatic test_full();
        int acc;
        for (int i = 0; i < 8; i++) load(32'h40 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 32'h40 + 32'(acc * 4), 1'b0, 1'b0, '0, '0);
            if (obs_ready) acc++;
        end
        checks++; if (acc !== FD) begin errors++; $display("FAIL full_accepted got %0d want %0d", acc, FD); end
        checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", obs_ready); end
        for (int i = 0; i < FD; i++) begin
            idle(1'b1);
            checks++; if (obs_valid !== 1'b1 || obs_data !== 32'hC0DE_0000 + 32'(i)) begin
                errors++; $display("FAIL full_drain%0d got v=%b d=%h want v=1 d=%h", i, obs_valid, obs_data, 32'hC0DE_0000 + 32'(i));
            end
            if (i == 0) begin
                checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL full_pop_cycle_ready got %b want 0", obs_ready); end
            end
            if (i == 1) begin
                checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL full_reraise got %b want 1", obs_ready); end
            end
        end
        idle(1'b1);
        checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL full_drained got %b want 0", obs_valid); end
    endtask

    task automatic test_rbw();
        load(32'h8, 32'h0000_0013);
        step(1'b1, 32'h8, 1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF);
        step(1'b1, 32'h8, 1'b1, 1'b0, '0, '0);
        idle(1'b1);
        checks++; if (obs_valid !== 1'b1 || obs_data !== 32'h0000_0013) begin
            errors++; $display("FAIL rbw_old got v=%b d=%h want v=1 d=00000013", obs_valid, obs_data);
        end
        idle(1'b1);
        checks++; if (obs_valid !== 1'b1 || obs_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rbw_new got v=%b d=%h want v=1 d=deadbeef", obs_valid, obs_data);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 32'h0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 32'h4, 1'b0, 1'b0, '0, '0);
        step(1'b1, 32'h0, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        mdl_reset();
        idle(1'b1);
        checks++; if (obs_valid !== 1'b0 || obs_ready !== 1'b0 || obs_data !== 32'h0) begin
            errors++; $display("FAIL midrst_state got v=%b r=%b d=%h want v=0 r=0 d=0", obs_valid, obs_ready, obs_data);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale%0d got %b want 0", i, obs_valid); end
        end
        step(1'b1, 32'h0, 1'b1, 1'b0, '0, '0);
        step(1'b1, 32'h4, 1'b1, 1'b0, '0, '0);
        idle(1'b1);
        checks++; if (obs_valid !== 1'b1 || obs_data !== 32'h0050_0093) begin
            errors++; $display("FAIL midrst_store0 got v=%b d=%h want v=1 d=00500093", obs_valid, obs_data);
        end
        idle(1'b1);
        checks++; if (obs_valid !== 1'b1 || obs_data !== 32'h00a0_0113) begin
            errors++; $display("FAIL midrst_store1 got v=%b d=%h want v=1 d=00a00113", obs_valid, obs_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] ra, la;
        int          sel;
        for (int i = 32; i < 64; i++) load(32'(i * 4), $urandom());
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 9);
            ra  = 32'($urandom_range(32, 63) * 4);
            if (sel == 0) ra = ra | 32'($urandom_range(1, 3));
            if (sel == 1) ra = 32'(4 * DEP) + 32'($urandom_range(0, 255) * 4);
            la  = 32'($urandom_range(32, 63) * 4);
            step($urandom_range(0, 9) < 6, ra, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 4) == 0, la, $urandom());
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, obs_ready, exp_ready); end
            checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, obs_valid, exp_valid); end
            checks++; if (obs_data !== exp_data)   begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h", cyc, obs_data, exp_data); end
            checks++; if (obs_err !== exp_err)     begin errors++; $display("FAIL rnd_err cyc %0d got %b want %b", cyc, obs_err, exp_err); end
        end
        for (int n = 0; n < 12; n++) idle(1'b1);
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d pending want 0", q.size()); end
        checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL rnd_final_valid got %b want 0", obs_valid); end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b0;
        cyc = 0;
        mdl_reset();
        test_reset();
        test_basic();
        test_errors();
        test_full();
        test_rbw();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
